// File: rtl/ccff_pkg.sv
// Shared definitions for the configuration-chain loader: FSM encodings and
// the helper that sizes the final (possibly partial) word of a pass.
package ccff_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_LOAD   = 2'd1;
    localparam state_t ST_VERIFY = 2'd2;
    localparam state_t ST_FIN    = 2'd3;

    // Number of bits of the last host word that land in the chain; a chain
    // length that is a whole number of words uses the full final word.
    function automatic int last_word_bits(input int chain_len, input int data_w);
        int rem;
        rem = chain_len % data_w;
        return (rem == 0) ? data_w : rem;
    endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// Single-word buffer that turns host words into an MSB-first bit stream.
// A new word is requested as the previous one drains so a continuous host
// stream produces one bit per cycle without bubbles.
module ccff_word_serializer
    import ccff_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int LAST_BITS = DATA_W
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              clear,
    input  logic              accept_en,
    input  logic              final_word,
    input  logic              shift,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [DATA_W-1:0] cfg_data,
    output logic              msb,
    output logic              has_bits
);

    localparam int REM_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] buf_q, buf_d;
    logic [REM_W-1:0]  rem_q, rem_d;

    // Ready generation, MSB-first shift and reload of the word buffer.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        buf_d     = buf_q;
        rem_d     = rem_q;
        cfg_ready = accept_en && ((rem_q == '0) || ((rem_q == REM_W'(1)) && shift));

        if (shift) begin
            buf_d = buf_q << 1;
            rem_d = rem_q - REM_W'(1);
        end
        if (cfg_valid && cfg_ready) begin
            buf_d = cfg_data;
            rem_d = final_word ? REM_W'(LAST_BITS) : REM_W'(DATA_W);
        end
        if (clear) begin
            buf_d = '0;
            rem_d = '0;
        end
    end

    // Buffer state registers.
    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            // NOTE: the data word is reset too, so the bit presented on ccff_head is never X.
            buf_q <= '0;
            rem_q <= '0;
        end else begin
            buf_q <= buf_d;
            rem_q <= rem_d;
        end
    end

    assign msb      = buf_q[DATA_W-1];
    assign has_bits = (rem_q != '0);

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Writer and checker for a ccff configuration chain: streams host words into
// ccff_head with a registered shift enable, and on an optional second pass
// compares ccff_tail against the resent bitstream, counting mismatches.
module ccff_bitstream_loader
    import ccff_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int CHAIN_LEN = 4096,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1),
    parameter int ERR_W     = 16
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic              verify_en,
    input  logic              abort,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [DATA_W-1:0] cfg_data,
    output logic              ccff_head,
    output logic              ccff_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              verify_pass,
    output logic [ERR_W-1:0]  err_cnt
);

    localparam int               LAST_BITS = last_word_bits(CHAIN_LEN, DATA_W);
    localparam logic [CNT_W-1:0] CHAIN_END = CNT_W'(CHAIN_LEN);

    state_t           state_q, state_d;
    logic             verify_q, verify_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic             ccff_head_q, ccff_head_d;
    logic             ccff_en_q, ccff_en_d;

    logic             active, shift, accept_en, final_word, buf_clear;
    logic             buf_msb, buf_has_bits;
    logic [CNT_W-1:0] bits_after;

    // Decide whether a bit shifts this cycle and whether the buffer may take a word.
    always_comb begin
        active     = (state_q == ST_LOAD) || (state_q == ST_VERIFY);
        shift      = active && !abort && buf_has_bits && (bit_cnt_q < CHAIN_END);
        bits_after = bit_cnt_q + CNT_W'(shift);
        accept_en  = active && !abort && (bits_after < CHAIN_END);
        final_word = int'(CHAIN_END - bits_after) <= DATA_W;
        buf_clear  = abort || !active || (bit_cnt_q == CHAIN_END);
    end

    ccff_word_serializer #(
        .DATA_W    (DATA_W),
        .LAST_BITS (LAST_BITS)
    ) u_serializer (
        .prog_clk   (prog_clk),
        .prog_reset (prog_reset),
        .clear      (buf_clear),
        .accept_en  (accept_en),
        .final_word (final_word),
        .shift      (shift),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_data   (cfg_data),
        .msb        (buf_msb),
        .has_bits   (buf_has_bits)
    );

    // Pass sequencing, bit counting, chain drive and tail comparison.
    always_comb begin
        state_d     = state_q;
        verify_d    = verify_q;
        bit_cnt_d   = bit_cnt_q;
        err_cnt_d   = err_cnt_q;
        ccff_head_d = ccff_head_q;
        ccff_en_d   = 1'b0;

        if (shift) begin
            ccff_en_d   = 1'b1;
            ccff_head_d = buf_msb;
            bit_cnt_d   = bit_cnt_q + CNT_W'(1);
        end

        // The chain shifts on this edge whenever ccff_en is high; the tail
        // still shows the bit written at the same position in the first pass.
        if ((state_q == ST_VERIFY) && ccff_en_q && (ccff_tail != ccff_head_q)
            && (err_cnt_q != {ERR_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_LOAD;
                    verify_d  = verify_en;
                    err_cnt_d = '0;
                    bit_cnt_d = '0;
                end
            end
            ST_LOAD: begin
                if (bit_cnt_q == CHAIN_END) begin
                    bit_cnt_d = '0;
                    state_d   = verify_q ? ST_VERIFY : ST_FIN;
                end
            end
            ST_VERIFY: begin
                if (bit_cnt_q == CHAIN_END) begin
                    bit_cnt_d = '0;
                    state_d   = ST_FIN;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort) begin
            state_d   = ST_IDLE;
            ccff_en_d = 1'b0;
            bit_cnt_d = '0;
        end
    end

    // Controller state registers.
    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            state_q     <= ST_IDLE;
            verify_q    <= 1'b0;
            bit_cnt_q   <= '0;
            err_cnt_q   <= '0;
            ccff_head_q <= 1'b0;
            ccff_en_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every flop samples the pre-edge values.
            state_q     <= state_d;
            verify_q    <= verify_d;
            bit_cnt_q   <= bit_cnt_d;
            err_cnt_q   <= err_cnt_d;
            ccff_head_q <= ccff_head_d;
            ccff_en_q   <= ccff_en_d;
        end
    end

    assign ccff_head   = ccff_head_q;
    assign ccff_en     = ccff_en_q;
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_FIN);
    assign verify_pass = (state_q == ST_FIN) && ((err_cnt_q == '0) || !verify_q);
    assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Directed bench for ccff_bitstream_loader: a 40-bit and a 36-bit chain
// (8-bit words), each closed by a behavioural shift-register chain model.
module tb_ccff_bitstream_loader;

    localparam int DATA_W = 8;
    localparam int ERR_W  = 16;

    typedef struct {
        string      name;
        bit         verify;
        int         flip_word;
        logic [7:0] flip_mask;
        int         gap_at;
        int         exp_en;
        int         exp_inner;
        int         exp_err;
        bit         exp_vp;
    } scen_t;

    logic prog_clk = 1'b0;
    logic prog_reset = 1'b1;
    logic sel = 1'b0;
    logic start = 1'b0, verify_en = 1'b0, abort = 1'b0, cfg_valid = 1'b0;
    logic [DATA_W-1:0] cfg_data = '0;

    logic rdy40, head40, en40, busy40, done40, vp40;
    logic rdy36, head36, en36, busy36, done36, vp36;
    logic [ERR_W-1:0] err40, err36;
    logic [39:0] chain40 = '0;
    logic [35:0] chain36 = '0;

    logic cfg_ready, ccff_head, ccff_en, busy, done, verify_pass;
    logic [ERR_W-1:0] err_cnt;

    always #5 prog_clk = ~prog_clk;

    ccff_bitstream_loader #(.DATA_W(DATA_W), .CHAIN_LEN(40), .ERR_W(ERR_W)) dut40 (
        .prog_clk(prog_clk), .prog_reset(prog_reset),
        .start(start & ~sel), .verify_en(verify_en), .abort(abort & ~sel),
        .cfg_valid(cfg_valid & ~sel), .cfg_ready(rdy40), .cfg_data(cfg_data),
        .ccff_head(head40), .ccff_en(en40), .ccff_tail(chain40[39]),
        .busy(busy40), .done(done40), .verify_pass(vp40), .err_cnt(err40)
    );

    ccff_bitstream_loader #(.DATA_W(DATA_W), .CHAIN_LEN(36), .ERR_W(ERR_W)) dut36 (
        .prog_clk(prog_clk), .prog_reset(prog_reset),
        .start(start & sel), .verify_en(verify_en), .abort(abort & sel),
        .cfg_valid(cfg_valid & sel), .cfg_ready(rdy36), .cfg_data(cfg_data),
        .ccff_head(head36), .ccff_en(en36), .ccff_tail(chain36[35]),
        .busy(busy36), .done(done36), .verify_pass(vp36), .err_cnt(err36)
    );

    // Behavioural configuration chains.
    always @(posedge prog_clk) begin
        if (en40) chain40 <= {chain40[38:0], head40};
        if (en36) chain36 <= {chain36[34:0], head36};
    end

    assign cfg_ready   = sel ? rdy36  : rdy40;
    assign ccff_head   = sel ? head36 : head40;
    assign ccff_en     = sel ? en36   : en40;
    assign busy        = sel ? busy36 : busy40;
    assign done        = sel ? done36 : done40;
    assign verify_pass = sel ? vp36   : vp40;
    assign err_cnt     = sel ? err36  : err40;

    int n_checks = 0, n_fail = 0;
    int en_count, inner_zeros, pending_zeros, head_moved, done_count;
    int ready_after, ready_lock, handshakes;
    bit seen_en, stop_host;
    logic last_head, last_vp;
    logic [ERR_W-1:0] last_err;
    logic [7:0] stream [0:9];
    logic [7:0] base [0:4];
    scen_t tbl [0:3];

    // Observe the selected DUT away from the active edge.
    always @(negedge prog_clk) begin
        if (ccff_en) begin
            en_count++;
            inner_zeros += pending_zeros;
            pending_zeros = 0;
            seen_en = 1'b1;
            last_head = ccff_head;
        end else if (seen_en && busy) begin
            pending_zeros++;
            if (ccff_head !== last_head) head_moved++;
        end
        if (done) begin
            done_count++;
            last_vp  = verify_pass;
            last_err = err_cnt;
        end
        if (busy && handshakes >= ready_lock && cfg_ready) ready_after++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic mon_reset();
        en_count = 0; inner_zeros = 0; pending_zeros = 0; head_moved = 0;
        done_count = 0; ready_after = 0; ready_lock = 1000; handshakes = 0;
        seen_en = 1'b0; last_vp = 1'b0; last_err = '0;
    endtask

    // Host side of the word stream; withholds valid for 3 ready cycles before word gap_at.
    task automatic host_stream(input int n, input int gap_at);
        int idx, gap_left, guard;
        idx = 0; guard = 0;
        gap_left = (gap_at >= 0) ? 3 : 0;
        while (idx < n && !stop_host && guard < 1000) begin
            @(negedge prog_clk);
            guard++;
            if (idx == gap_at && gap_left > 0) begin
                cfg_valid = 1'b0;
                #1;
                if (cfg_ready) gap_left--;
            end else begin
                cfg_valid = 1'b1;
                cfg_data  = stream[idx];
                #1;
                if (cfg_ready) begin
                    idx++;
                    handshakes++;
                end
            end
        end
        @(negedge prog_clk);
        cfg_valid = 1'b0;
    endtask

    task automatic start_op(input bit v);
        @(negedge prog_clk);
        start = 1'b1; verify_en = v;
        @(negedge prog_clk);
        start = 1'b0; verify_en = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 500) begin
            @(negedge prog_clk);
            n++;
        end
        check({name, "_finished"}, busy, 0);
        @(negedge prog_clk);
        #1;
    endtask

    task automatic run_scenario(input int i, input int seed);
        scen_t s;
        logic [39:0] exp_chain;
        int total, off;
        s = tbl[i];
        for (int k = 0; k < 5; k++) begin
            stream[k]     = base[k] ^ 8'(seed * 19);
            stream[k + 5] = stream[k] ^ ((k == s.flip_word) ? s.flip_mask : 8'h00);
        end
        total = s.verify ? 10 : 5;
        off   = s.verify ? 5 : 0;
        exp_chain = '0;
        for (int k = 0; k < 5; k++) exp_chain = (exp_chain << 8) | 40'(stream[off + k]);

        sel = 1'b0;
        mon_reset();
        start_op(s.verify);
        check({s.name, "_busy"}, busy, 1);
        host_stream(total, s.gap_at);
        check({s.name, "_words_taken"}, handshakes, total);
        wait_idle(s.name);
        check({s.name, "_shift_count"}, en_count, s.exp_en);
        check({s.name, "_done_pulses"}, done_count, 1);
        check({s.name, "_verify_pass"}, last_vp, s.exp_vp);
        check({s.name, "_err_at_done"}, last_err, s.exp_err);
        check({s.name, "_err_held"}, err_cnt, s.exp_err);
        check({s.name, "_chain"}, chain40, exp_chain);
        check({s.name, "_head_held"}, head_moved, 0);
        if (s.exp_inner >= 0) check({s.name, "_stall_cycles"}, inner_zeros, s.exp_inner);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d checks so far", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [39:0] exp40;
        int n;

        base[0] = 8'hA5; base[1] = 8'h3C; base[2] = 8'hF0; base[3] = 8'h0F; base[4] = 8'h96;
        //            name           ver flipw mask   gap  en  inner err vp
        tbl[0] = '{"load",          1'b0, -1, 8'h00, -1, 40,  0,   0, 1'b1};
        tbl[1] = '{"verify_same",   1'b1, -1, 8'h00, -1, 80, -1,   0, 1'b1};
        tbl[2] = '{"verify_flip",   1'b1,  2, 8'h08, -1, 80, -1,   1, 1'b0};
        tbl[3] = '{"load_gap",      1'b0, -1, 8'h00,  3, 40,  3,   0, 1'b1};
        mon_reset();
        stop_host = 1'b0;

        // Reset state of both instances.
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_en", ccff_en, 0);
        check("rst_head", ccff_head, 0);
        check("rst_ready", cfg_ready, 0);
        check("rst_vp", verify_pass, 0);
        check("rst_err", err_cnt, 0);
        check("rst36_outs", {busy36, en36, rdy36, done36, err36}, 0);
        repeat (2) @(negedge prog_clk);
        prog_reset = 1'b0;

        // cfg_valid in IDLE is not consumed; abort beats a simultaneous start.
        @(negedge prog_clk);
        cfg_valid = 1'b1; cfg_data = 8'hFF;
        #1;
        check("idle_ready", cfg_ready, 0);
        start = 1'b1; abort = 1'b1;
        @(negedge prog_clk);
        start = 1'b0; abort = 1'b0; cfg_valid = 1'b0;
        check("abort_beats_start", busy, 0);

        for (int i = 0; i < 4; i++) run_scenario(i, i + 1);

        // Partial final word on the 36-bit chain.
        for (int k = 0; k < 5; k++) stream[k] = base[k] ^ 8'h5A;
        exp40 = '0;
        for (int k = 0; k < 5; k++) exp40 = (exp40 << 8) | 40'(stream[k]);
        sel = 1'b1;
        mon_reset();
        ready_lock = 5;
        start_op(1'b0);
        check("partial_busy", busy, 1);
        host_stream(5, -1);
        check("partial_words_taken", handshakes, 5);
        wait_idle("partial");
        check("partial_shift_count", en_count, 36);
        check("partial_done_pulses", done_count, 1);
        check("partial_verify_pass", last_vp, 1);
        check("partial_ready_after_last", ready_after, 0);
        check("partial_chain", chain36, exp40[39:4]);

        // Abort after 17 shifts, then a normal load.
        sel = 1'b0;
        for (int k = 0; k < 5; k++) stream[k] = base[k] ^ 8'hC3;
        mon_reset();
        start_op(1'b0);
        fork
            host_stream(5, -1);
            begin
                n = 0;
                while (en_count < 17 && n < 200) begin
                    @(negedge prog_clk);
                    #2;
                    n++;
                end
                check("abort_reached_17", en_count, 17);
                abort = 1'b1; stop_host = 1'b1;
                @(posedge prog_clk);
                #1;
                abort = 1'b0;
                check("abort_busy_low", busy, 0);
                check("abort_en_low", ccff_en, 0);
            end
        join
        repeat (4) @(negedge prog_clk);
        #1;
        check("abort_shift_count", en_count, 17);
        check("abort_no_done", done_count, 0);
        check("abort_ready_low", cfg_ready, 0);
        stop_host = 1'b0;
        run_scenario(0, 9);

        // Asynchronous reset in the middle of a load.
        mon_reset();
        start_op(1'b0);
        fork
            host_stream(5, -1);
            begin
                n = 0;
                while (en_count < 5 && n < 200) begin
                    @(negedge prog_clk);
                    #2;
                    n++;
                end
                prog_reset = 1'b1; stop_host = 1'b1;
                #1;
                check("async_rst_en", ccff_en, 0);
                check("async_rst_busy", busy, 0);
                @(negedge prog_clk);
                prog_reset = 1'b0;
            end
        join
        #1;
        check("async_rst_ready", cfg_ready, 0);
        check("async_rst_no_done", done_count, 0);
        stop_host = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
